// File: rtl/uart_apb_csr.sv
// uart_apb_csr: APB3 control/status register block for the UART.
// Decodes the register map, runs the IDLE/SETUP/ACCESS handshake with
// WAIT_STATES wait cycles, and generates the data-path strobes, sticky
// line status, interrupt identification and the registered irq.
// Optional feature macro: UART_CSR_PSLVERR_EN. When defined, unmapped
// accesses and writes to LSR complete with pslverr=1. When undefined,
// pslverr is tied to 0 and such accesses are ignored.
module uart_apb_csr #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int DIV_W       = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic              pready,
    output logic [DATA_W-1:0] prdata,
    output logic              pslverr,
    input  logic [7:0]        rx_data,
    input  logic              rx_pe,
    input  logic              rx_fe,
    input  logic              rx_valid,
    output logic              rx_pop,
    output logic [7:0]        thr_data,
    output logic              thr_push,
    input  logic              thr_empty,
    input  logic              tx_idle,
    output logic              erbi,
    output logic              etbei,
    output logic              elsi,
    output logic              fifoen,
    output logic [1:0]        rxfiftl,
    output logic              rxclr,
    output logic              txclr,
    output logic [1:0]        wls,
    output logic              stb,
    output logic              pen,
    output logic              eps,
    output logic              sp,
    output logic              loop,
    output logic [DIV_W-1:0]  divisor,
    output logic              urrst,
    output logic              utrst,
    output logic              irq
);
    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

    localparam logic [3:0]        WS    = 4'(WAIT_STATES);
    localparam logic [ADDR_W-1:0] A_RBR = ADDR_W'('h00);
    localparam logic [ADDR_W-1:0] A_IER = ADDR_W'('h04);
    localparam logic [ADDR_W-1:0] A_IIR = ADDR_W'('h08);
    localparam logic [ADDR_W-1:0] A_LCR = ADDR_W'('h0C);
    localparam logic [ADDR_W-1:0] A_LSR = ADDR_W'('h14);
    localparam logic [ADDR_W-1:0] A_DLL = ADDR_W'('h20);
    localparam logic [ADDR_W-1:0] A_DLH = ADDR_W'('h24);
    localparam logic [ADDR_W-1:0] A_PWR = ADDR_W'('h30);

    state_t             r_state, w_next;
    logic [3:0]         r_wait;
    logic [2:0]         r_ier;
    logic [6:0]         r_lcr;
    logic [7:0]         r_dll;
    logic [DIV_W-9:0]   r_dlh;
    logic [1:0]         r_pwr;
    logic               r_fifoen;
    logic [1:0]         r_rxfiftl;
    logic               r_pe, r_fe, r_thre_int, r_thre_q, r_etbei_q, r_irq;

    logic               w_done, w_err, w_wr, w_rd;
    logic               w_hit_rbr, w_hit_ier, w_hit_iir, w_hit_lcr;
    logic               w_hit_lsr, w_hit_dll, w_hit_dlh, w_hit_pwr;
    logic [3:0]         w_iid;
    logic [7:0]         w_iir, w_lsr;
    logic [DATA_W-1:0]  w_rdata;
    logic               w_thre_set, w_thre_clr;
    logic               w_unused;

    assign w_hit_rbr = (paddr == A_RBR);
    assign w_hit_ier = (paddr == A_IER);
    assign w_hit_iir = (paddr == A_IIR);
    assign w_hit_lcr = (paddr == A_LCR);
    assign w_hit_lsr = (paddr == A_LSR);
    assign w_hit_dll = (paddr == A_DLL);
    assign w_hit_dlh = (paddr == A_DLH);
    assign w_hit_pwr = (paddr == A_PWR);

    // Completion is the last ACCESS cycle; every side effect keys off it.
    assign w_done = (r_state == S_ACCESS) && (r_wait == WS);

`ifdef UART_CSR_PSLVERR_EN
    logic w_mapped;
    assign w_mapped = w_hit_rbr | w_hit_ier | w_hit_iir | w_hit_lcr |
                      w_hit_lsr | w_hit_dll | w_hit_dlh | w_hit_pwr;
    assign w_err    = w_done & (~w_mapped | (pwrite & w_hit_lsr));
`else
    assign w_err    = 1'b0;
`endif

    assign w_wr    = w_done & pwrite & ~w_err;
    assign w_rd    = w_done & ~pwrite & ~w_err;
    assign pready  = w_done;
    assign pslverr = w_err;

    // APB handshake state and wait-state counter.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state <= S_IDLE;
            r_wait  <= '0;
        end else begin
            r_state <= w_next;
            r_wait  <= (r_state == S_ACCESS && r_wait != WS) ? r_wait + 4'd1 : 4'd0;
        end
    end

    // Next state: penable without a preceding setup phase is ignored.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (psel && !penable) w_next = S_SETUP;
            S_SETUP:  w_next = S_ACCESS;
            S_ACCESS: if (w_done) w_next = (psel && !penable) ? S_SETUP : S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Interrupt identification, highest priority first.
    always_comb begin
        w_iid = 4'h1;
        if ((r_pe | r_fe) & r_ier[2])   w_iid = 4'h6;
        else if (rx_valid & r_ier[0])   w_iid = 4'h4;
        else if (r_thre_int & r_ier[1]) w_iid = 4'h2;
    end

    assign w_iir = {r_fifoen, r_fifoen, 2'b00, w_iid};
    assign w_lsr = {1'b0, thr_empty & tx_idle, thr_empty, 1'b0, r_fe, r_pe, 1'b0, rx_valid};

    // Read mux; unmapped addresses read as zero.
    always_comb begin
        w_rdata = '0;
        if (w_hit_rbr)      w_rdata[7:0]       = rx_data;
        else if (w_hit_ier) w_rdata[2:0]       = r_ier;
        else if (w_hit_iir) w_rdata[7:0]       = w_iir;
        else if (w_hit_lcr) w_rdata[6:0]       = r_lcr;
        else if (w_hit_lsr) w_rdata[7:0]       = w_lsr;
        else if (w_hit_dll) w_rdata[7:0]       = r_dll;
        else if (w_hit_dlh) w_rdata[DIV_W-9:0] = r_dlh;
        else if (w_hit_pwr) w_rdata[14:13]     = r_pwr;
    end

    assign prdata   = w_rd ? w_rdata : '0;
    assign rx_pop   = w_rd & w_hit_rbr;
    assign thr_push = w_wr & w_hit_rbr;
    assign thr_data = pwdata[7:0];
    assign rxclr    = w_wr & w_hit_iir & pwdata[1];
    assign txclr    = w_wr & w_hit_iir & pwdata[2];

    // THRE interrupt: armed on THRE rising or on etbei rising while THRE is set.
    assign w_thre_set = thr_empty & (~r_thre_q | (r_ier[1] & ~r_etbei_q));
    assign w_thre_clr = thr_push | (w_rd & w_hit_iir & (w_iid == 4'h2));

    // Configuration registers, sticky status and the registered irq.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_ier      <= '0;
            r_lcr      <= '0;
            r_dll      <= '0;
            r_dlh      <= '0;
            r_pwr      <= '0;
            r_fifoen   <= 1'b0;
            r_rxfiftl  <= '0;
            r_pe       <= 1'b0;
            r_fe       <= 1'b0;
            r_thre_int <= 1'b0;
            r_thre_q   <= 1'b0;
            r_etbei_q  <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            if (w_wr && w_hit_ier) r_ier <= pwdata[2:0];
            if (w_wr && w_hit_lcr) r_lcr <= pwdata[6:0];
            if (w_wr && w_hit_dll) r_dll <= pwdata[7:0];
            if (w_wr && w_hit_dlh) r_dlh <= pwdata[DIV_W-9:0];
            if (w_wr && w_hit_pwr) r_pwr <= pwdata[14:13];
            if (w_wr && w_hit_iir) begin
                r_fifoen  <= pwdata[0];
                r_rxfiftl <= pwdata[7:6];
            end
            // Set wins over the clearing LSR read.
            if (rx_pop && rx_pe)         r_pe <= 1'b1;
            else if (w_rd && w_hit_lsr)  r_pe <= 1'b0;
            if (rx_pop && rx_fe)         r_fe <= 1'b1;
            else if (w_rd && w_hit_lsr)  r_fe <= 1'b0;
            if (w_thre_set)              r_thre_int <= 1'b1;
            else if (w_thre_clr)         r_thre_int <= 1'b0;
            r_thre_q  <= thr_empty;
            r_etbei_q <= r_ier[1];
            r_irq     <= ~w_iid[0];
        end
    end

    assign {elsi, etbei, erbi}           = r_ier;
    assign {loop, sp, eps, pen, stb, wls} = r_lcr;
    assign fifoen   = r_fifoen;
    assign rxfiftl  = r_rxfiftl;
    assign divisor  = {r_dlh, r_dll};
    assign {utrst, urrst} = r_pwr;
    assign irq      = r_irq;

    assign w_unused = ^{pwdata[DATA_W-1:15], pwdata[12:8]};
endmodule

// File: tb/tb_uart_apb_csr.sv
// tb_uart_apb_csr: randomized APB traffic against a register-file model,
// checked every cycle, plus directed sequences with literal expectations.
module tb_uart_apb_csr;
  localparam int WS = 2;

  logic        pclk = 1'b0, presetn = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic        pready, pslverr;
  logic [31:0] prdata;
  logic [7:0]  rx_data = '0;
  logic        rx_pe = 1'b0, rx_fe = 1'b0, rx_valid = 1'b0;
  logic        rx_pop, thr_push;
  logic [7:0]  thr_data;
  logic        thr_empty = 1'b0, tx_idle = 1'b0;
  logic        erbi, etbei, elsi, fifoen, rxclr, txclr;
  logic [1:0]  rxfiftl, wls;
  logic        stb, pen, eps, sp, loop, urrst, utrst, irq;
  logic [15:0] divisor;

  always #5 pclk = ~pclk;

  uart_apb_csr #(.ADDR_W(8), .DATA_W(32), .DIV_W(16), .WAIT_STATES(WS)) dut (
    .pclk(pclk), .presetn(presetn), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pready(pready), .prdata(prdata), .pslverr(pslverr),
    .rx_data(rx_data), .rx_pe(rx_pe), .rx_fe(rx_fe), .rx_valid(rx_valid), .rx_pop(rx_pop),
    .thr_data(thr_data), .thr_push(thr_push), .thr_empty(thr_empty), .tx_idle(tx_idle),
    .erbi(erbi), .etbei(etbei), .elsi(elsi), .fifoen(fifoen), .rxfiftl(rxfiftl),
    .rxclr(rxclr), .txclr(txclr), .wls(wls), .stb(stb), .pen(pen), .eps(eps), .sp(sp),
    .loop(loop), .divisor(divisor), .urrst(urrst), .utrst(utrst), .irq(irq));

  int n_chk = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Writable registers kept as a word-indexed register file with write masks.
  logic [31:0] m_rf [0:15];
  logic        m_pe, m_fe, m_thre, m_prev_te, m_prev_etb, m_irq, m_busy;
  int          m_left;

  function automatic logic is_mapped(input logic [7:0] a);
    return a inside {8'h00, 8'h04, 8'h08, 8'h0C, 8'h14, 8'h20, 8'h24, 8'h30};
  endfunction

  function automatic logic [31:0] wmask(input logic [7:0] a);
    case (a)
      8'h04: return 32'h7;
      8'h08: return 32'hC1;
      8'h0C: return 32'h7F;
      8'h20, 8'h24: return 32'hFF;
      8'h30: return 32'h6000;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [3:0] m_iid();
    if ((m_pe || m_fe) && m_rf[1][2]) return 4'h6;
    if (rx_valid && m_rf[1][0])       return 4'h4;
    if (m_thre && m_rf[1][1])         return 4'h2;
    return 4'h1;
  endfunction

  function automatic logic [31:0] exp_read(input logic [7:0] a);
    case (a)
      8'h00: return {24'h0, rx_data};
      8'h08: return {24'h0, m_rf[2][0], m_rf[2][0], 2'b00, m_iid()};
      8'h14: return {25'h0, thr_empty & tx_idle, thr_empty, 1'b0, m_fe, m_pe, 1'b0, rx_valid};
      8'h04, 8'h0C, 8'h20, 8'h24, 8'h30: return m_rf[a[5:2]];
      default: return 32'h0;
    endcase
  endfunction

  int          thr_push_cnt = 0;
  logic [7:0]  last_thr = '0;

  // Compare DUT against the model every cycle, then advance the model.
  always @(negedge pclk) begin : cmp
    logic done, rd, wr, tset, tclr, etb_now;
    logic [3:0] iid;
    if (!presetn) begin
      for (int i = 0; i < 16; i++) m_rf[i] = '0;
      m_pe = 0; m_fe = 0; m_thre = 0; m_prev_te = 0; m_prev_etb = 0;
      m_irq = 0; m_busy = 0; m_left = 0;
    end
    done = m_busy && (m_left == 0);
    rd   = done && !pwrite;
    wr   = done && pwrite;
    iid  = m_iid();
    chk("pready", pready, done);
    chk("pslverr", pslverr, 0);
    chk("prdata", prdata, rd ? exp_read(paddr) : 32'h0);
    chk("rx_pop", rx_pop, rd && paddr == 8'h00);
    chk("thr_push", thr_push, wr && paddr == 8'h00);
    chk("thr_data", thr_data, pwdata[7:0]);
    chk("rxclr", rxclr, wr && paddr == 8'h08 && pwdata[1]);
    chk("txclr", txclr, wr && paddr == 8'h08 && pwdata[2]);
    chk("cfg", {erbi, etbei, elsi, fifoen, rxfiftl, wls, stb, pen, eps, sp, loop, urrst, utrst},
        {m_rf[1][0], m_rf[1][1], m_rf[1][2], m_rf[2][0], m_rf[2][7:6], m_rf[3][1:0],
         m_rf[3][2], m_rf[3][3], m_rf[3][4], m_rf[3][5], m_rf[3][6], m_rf[12][13], m_rf[12][14]});
    chk("divisor", divisor, {m_rf[9][7:0], m_rf[8][7:0]});
    chk("irq", irq, m_irq);
    if (thr_push) begin thr_push_cnt++; last_thr = thr_data; end
    if (presetn) begin
      etb_now = m_rf[1][1];
      tset = thr_empty && (!m_prev_te || (etb_now && !m_prev_etb));
      tclr = (wr && paddr == 8'h00) || (rd && paddr == 8'h08 && iid == 4'h2);
      m_irq = (iid != 4'h1);
      if (rd && paddr == 8'h00 && rx_pe) m_pe = 1; else if (rd && paddr == 8'h14) m_pe = 0;
      if (rd && paddr == 8'h00 && rx_fe) m_fe = 1; else if (rd && paddr == 8'h14) m_fe = 0;
      if (tset) m_thre = 1; else if (tclr) m_thre = 0;
      m_prev_te  = thr_empty;
      m_prev_etb = etb_now;
      if (wr && is_mapped(paddr) && wmask(paddr) != 0) m_rf[paddr[5:2]] = pwdata & wmask(paddr);
      // Transfer completes WS+2 cycles after its setup cycle.
      if (done) begin m_busy = psel && !penable; m_left = WS + 1; end
      else if (m_busy) m_left--;
      else if (psel && !penable) begin m_busy = 1; m_left = WS + 1; end
    end
  end

  // ---------------- stimulus ----------------
  logic rand_en = 1'b0;

  always @(posedge pclk) begin
    if (rand_en) begin
      #1;
      rx_data   = 8'($urandom);
      rx_pe     = ($urandom_range(0, 3) == 0);
      rx_fe     = ($urandom_range(0, 3) == 0);
      rx_valid  = $urandom_range(0, 1) == 1;
      thr_empty = ($urandom_range(0, 3) != 0);
      tx_idle   = $urandom_range(0, 1) == 1;
    end
  end

  task automatic apb(input logic w, input logic [7:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output int lat);
    logic got;
    @(posedge pclk); #1;
    psel = 1; penable = 0; pwrite = w; paddr = a; pwdata = d;
    @(posedge pclk); #1;
    penable = 1;
    lat = 0; rd = '0; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge pclk);
      lat++;
      if (pready) begin rd = prdata; got = 1; end
    end
    if (!got) begin
      n_chk++; n_err++;
      $display("FAIL apb_timeout addr=%0h no pready within 20 cycles", a);
    end
    @(posedge pclk); #1;
    psel = 0; penable = 0; pwrite = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    int lat;
    logic [7:0] addrs [10];
    addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h14, 8'h20, 8'h24, 8'h30, 8'h3C, 8'h10};

    repeat (3) @(posedge pclk);
    @(negedge pclk);
    chk("rst_divisor", divisor, 16'h0);
    chk("rst_irq", irq, 0);
    chk("rst_pready", pready, 0);
    chk("rst_prdata", prdata, 32'h0);
    chk("rst_cfg", {erbi, etbei, elsi, fifoen, rxfiftl, wls}, 8'h0);
    @(posedge pclk); #1 presetn = 1;

    apb(0, 8'h08, 0, rd, lat);        chk("rst_iir", rd, 32'h01);

    apb(1, 8'h20, 32'h34, rd, lat);   chk("lat_dll", lat, 4);
    apb(1, 8'h24, 32'h12, rd, lat);   chk("lat_dlh", lat, 4);
    chk("divisor_1234", divisor, 16'h1234);

    apb(1, 8'h08, 32'hC7, rd, lat);
    chk("fcr_fifoen", fifoen, 1);
    chk("fcr_rxfiftl", rxfiftl, 2'd3);
    apb(0, 8'h08, 0, rd, lat);        chk("iir_fifo_bits", rd, 32'hC1);

    // Receive path with a parity error tag.
    @(posedge pclk); #1 rx_valid = 1; rx_pe = 1; rx_data = 8'hA5;
    apb(1, 8'h04, 32'h5, rd, lat);
    apb(0, 8'h00, 0, rd, lat);        chk("rbr_data", rd, 32'hA5);
    apb(0, 8'h08, 0, rd, lat);        chk("iir_ls", rd, 32'hC6);
    repeat (2) @(posedge pclk); #1;   chk("irq_ls", irq, 1);
    apb(0, 8'h14, 0, rd, lat);        chk("lsr_pe", rd, 32'h05);
    apb(0, 8'h08, 0, rd, lat);        chk("iir_rda", rd, 32'hC4);
    @(posedge pclk); #1 rx_valid = 0; rx_pe = 0;

    // THRE interrupt.
    apb(1, 8'h04, 32'h2, rd, lat);
    @(posedge pclk); #1 thr_empty = 1;
    repeat (3) @(posedge pclk); #1;   chk("irq_thre", irq, 1);
    apb(0, 8'h08, 0, rd, lat);        chk("iir_thre", rd, 32'hC2);
    repeat (2) @(posedge pclk); #1;   chk("irq_thre_clr", irq, 0);
    apb(1, 8'h00, 32'h55, rd, lat);
    chk("thr_push_cnt", thr_push_cnt, 1);
    chk("thr_last", last_thr, 8'h55);

    // penable without setup must be ignored.
    @(posedge pclk); #1 psel = 1; penable = 1; pwrite = 1; paddr = 8'h20; pwdata = 32'hFF;
    repeat (3) @(posedge pclk); #1 psel = 0; penable = 0; pwrite = 0;
    chk("no_setup_div", divisor, 16'h1234);

    // Unmapped write and LSR write are silently dropped.
    apb(1, 8'h3C, 32'hFFFF_FFFF, rd, lat);
    apb(1, 8'h14, 32'hFFFF_FFFF, rd, lat);
    chk("unmapped_div", divisor, 16'h1234);
    chk("unmapped_lcr", {wls, stb, pen, eps, sp, loop}, 7'h0);
    apb(0, 8'h3C, 0, rd, lat);        chk("unmapped_rd", rd, 32'h0);

    // Randomized traffic with randomized line inputs.
    rand_en = 1;
    for (int n = 0; n < 300; n++) begin
      apb($urandom_range(0, 1) == 1, addrs[$urandom_range(0, 9)], $urandom, rd, lat);
      repeat ($urandom_range(0, 2)) @(posedge pclk);
    end
    rand_en = 0;

    // Reset in the middle of a DLL write: nothing may land afterwards.
    @(posedge pclk); #1 psel = 1; penable = 0; pwrite = 1; paddr = 8'h20; pwdata = 32'h99;
    @(posedge pclk); #1 penable = 1;
    @(posedge pclk); #1 presetn = 0;
    repeat (2) @(posedge pclk); #1 presetn = 1;
    repeat (4) @(posedge pclk); #1 psel = 0; penable = 0; pwrite = 0;
    chk("abort_div", divisor, 16'h0);
    repeat (2) @(posedge pclk);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
